// File: rtl/mnacidpro_pkg.sv
// mnacidpro_pkg: shared state enum, valve bit map, ctrl patterns and pump step table
package mnacidpro_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LYSIS, ST_WASH, ST_ELUTE} state_e;

    localparam int C_LYSIS     = 0;
    localparam int C_WASH      = 1;
    localparam int C_ELUTE     = 2;
    localparam int C_DEAD_END  = 3;
    localparam int C_VERTICAL  = 4;
    localparam int C_HORIZ     = 5;
    localparam int C_WASTE     = 6;
    localparam int C_BEAD      = 7;
    localparam int C_LOOP_EXIT = 8;
    localparam int C_BEAD_TRAP = 9;
    localparam int C_COLLECT   = 10;

    localparam logic [10:0] CTRL_IDLE  = 11'h000;
    localparam logic [10:0] CTRL_LYSIS = 11'((1 << C_LYSIS) | (1 << C_HORIZ) | (1 << C_WASTE) | (1 << C_BEAD_TRAP));
    localparam logic [10:0] CTRL_WASH  = 11'((1 << C_WASH) | (1 << C_HORIZ) | (1 << C_WASTE) | (1 << C_BEAD_TRAP));
    localparam logic [10:0] CTRL_ELUTE = 11'((1 << C_ELUTE) | (1 << C_VERTICAL) | (1 << C_LOOP_EXIT) |
                                             (1 << C_BEAD_TRAP) | (1 << C_COLLECT));

    // entry 0 is the first step of a stroke
    localparam logic [5:0][2:0] PUMP_PAT = {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

endpackage

// File: rtl/mnacidpro_pump_phase.sv
// mnacidpro_pump_phase: peristaltic pump stepping with clock divider and stroke counting
module mnacidpro_pump_phase
    import mnacidpro_pkg::*;
#(
    parameter int PUMP_DIV = 2,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [CW-1:0] n_strokes,
    output logic [2:0]    pump,
    output logic          strokes_done
);

    localparam int DW = PUMP_DIV > 1 ? $clog2(PUMP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PUMP_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] stroke_q, stroke_d;
    logic          step_end, stroke_end;

    // strokes_done flags the last cycle of the last stroke; counters restart whenever go drops
    always_comb begin
        step_end     = div_q == DIV_LAST;
        stroke_end   = step_end && step_q == 3'd5;
        strokes_done = go && stroke_end && stroke_q == n_strokes - 1'b1;
        pump         = go ? PUMP_PAT[step_q] : 3'b000;
        div_d        = step_end ? '0 : div_q + 1'b1;
        step_d       = !step_end ? step_q : stroke_end ? 3'd0 : step_q + 3'd1;
        stroke_d     = stroke_end ? stroke_q + 1'b1 : stroke_q;
        if (!go || strokes_done) begin
            div_d    = '0;
            step_d   = '0;
            stroke_d = '0;
        end
    end

    // divider, step and stroke registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            step_q   <= '0;
            stroke_q <= '0;
        end else begin
            div_q    <= div_d;
            step_q   <= step_d;
            stroke_q <= stroke_d;
        end
    end

endmodule

// File: rtl/mnacidpro_valve_seq.sv
// mnacidpro_valve_seq: lysis/wash/elute valve sequencer with rotating collect outlet
module mnacidpro_valve_seq
    import mnacidpro_pkg::*;
#(
    parameter int SIZE     = 5,
    parameter int SETTLE   = 4,
    parameter int PUMP_DIV = 2,
    parameter int CW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CW-1:0]   n_lysis,
    input  logic [CW-1:0]   n_wash,
    input  logic [CW-1:0]   n_elute,
    output logic [10:0]     ctrl,
    output logic [2:0]      pump,
    output logic [SIZE-1:0] collect_sel,
    output logic            busy,
    output logic            done,
    output logic            aborted
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_N    = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [CW-1:0] nl_q, nl_d, nw_q, nw_d, ne_q, ne_d, n_cur;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d, aborted_q, aborted_d;
    logic          go, phase_end, strokes_done;

    mnacidpro_pump_phase #(.PUMP_DIV(PUMP_DIV), .CW(CW)) u_pump (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .n_strokes   (n_cur),
        .pump        (pump),
        .strokes_done(strokes_done)
    );

    // sequencing: settle window then strokes per phase; abort beats start and phase completion
    always_comb begin
        busy      = state_q != ST_IDLE;
        n_cur     = state_q == ST_LYSIS ? nl_q : state_q == ST_WASH ? nw_q : ne_q;
        go        = busy && settle_q == SETTLE_N;
        phase_end = busy && ((settle_q == SETTLE_LAST && n_cur == '0) || strokes_done);
        state_d   = state_q;
        settle_d  = settle_q == SETTLE_N ? settle_q : settle_q + 1'b1;
        nl_d      = nl_q;
        nw_d      = nw_q;
        ne_d      = ne_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if (!busy) begin
            settle_d = '0;
            if (start) begin
                state_d = ST_LYSIS;
                nl_d    = n_lysis;
                nw_d    = n_wash;
                ne_d    = n_elute;
            end
        end else if (abort) begin
            state_d   = ST_IDLE;
            settle_d  = '0;
            aborted_d = 1'b1;
        end else if (phase_end) begin
            settle_d = '0;
            state_d  = state_q == ST_LYSIS ? ST_WASH : state_q == ST_WASH ? ST_ELUTE : ST_IDLE;
            done_d   = state_q == ST_ELUTE;
            idx_d    = state_q != ST_ELUTE ? idx_q : idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
        end
    end

    // valve pattern and outlet select follow the registered state
    always_comb begin
        ctrl        = state_q == ST_LYSIS ? CTRL_LYSIS : state_q == ST_WASH ? CTRL_WASH :
                      state_q == ST_ELUTE ? CTRL_ELUTE : CTRL_IDLE;
        collect_sel = state_q == ST_ELUTE ? SIZE'(1) << idx_q : '0;
        done        = done_q;
        aborted     = aborted_q;
    end

    // state, latched stroke counts, outlet index and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            nl_q      <= '0;
            nw_q      <= '0;
            ne_q      <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            nl_q      <= nl_d;
            nw_q      <= nw_d;
            ne_q      <= ne_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: tb/tb_mnacidpro_valve_seq.sv
// tb_mnacidpro_valve_seq: scoreboard bench, one record per finished valve phase
module tb_mnacidpro_valve_seq;

    localparam int SIZE = 5;
    localparam int CW   = 16;
    localparam logic [10:0] P_LYS = 11'h261, P_WSH = 11'h262, P_ELU = 11'h714;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [31:0] dur;
        logic [4:0]  sel;
        logic [35:0] trace;
        logic [19:0] stat;
    } rec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CW-1:0] n_lysis = '0, n_wash = '0, n_elute = '0;
    logic [10:0] ctrl;
    logic [2:0] pump;
    logic [SIZE-1:0] collect_sel;
    logic busy, done, aborted;

    int checks = 0, errors = 0;
    rec_t exp_q[$];

    mnacidpro_valve_seq #(.SIZE(SIZE), .SETTLE(4), .PUMP_DIV(2), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .n_lysis(n_lysis), .n_wash(n_wash), .n_elute(n_elute),
        .ctrl(ctrl), .pump(pump), .collect_sel(collect_sel),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // pump values seen from the end of settle, for the cycles the phase actually lasted
    function automatic logic [35:0] exp_trace(input int n, input int dur);
        logic [35:0] full, t;
        full = {3'b001, 3'b001, 3'b011, 3'b011, 3'b010, 3'b010,
                3'b110, 3'b110, 3'b100, 3'b100, 3'b101, 3'b101};
        t = '0;
        for (int i = 0; i < 12; i++)
            if (n != 0 && 4 + i < dur) t[i*3 +: 3] = full[i*3 +: 3];
        return t;
    endfunction

    task automatic push(input logic [10:0] c, input int n, input int dur, input logic [4:0] sel,
                        input logic [10:0] end_ctrl, input logic d, input logic a, input logic b);
        rec_t r;
        r.ctrl  = c;
        r.dur   = dur;
        r.sel   = sel;
        r.trace = exp_trace(n, dur);
        r.stat  = {3'b000, end_ctrl, 3'b000, d, a, b};
        exp_q.push_back(r);
    endtask

    task automatic pulse_start(input int nl, input int nw, input int ne);
        @(negedge clk);
        n_lysis = CW'(nl);
        n_wash  = CW'(nw);
        n_elute = CW'(ne);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 5000 && busy; k++) @(negedge clk);
        if (k == 5000) cmp("idle_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_ctrl(input logic [10:0] c);
        int k;
        for (k = 0; k < 5000 && ctrl !== c; k++) @(negedge clk);
        if (k == 5000) cmp("ctrl_timeout", 64'(ctrl), 64'(c));
    endtask

    task automatic full_run(input int nl, input int nw, input int ne, input logic [4:0] sel);
        push(P_LYS, nl, 4 + 12 * nl, 5'b0, P_WSH, 1'b0, 1'b0, 1'b1);
        push(P_WSH, nw, 4 + 12 * nw, 5'b0, P_ELU, 1'b0, 1'b0, 1'b1);
        push(P_ELU, ne, 4 + 12 * ne, sel, 11'h000, 1'b1, 1'b0, 1'b0);
        pulse_start(nl, nw, ne);
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        cmp({tag, "_ctrl"}, 64'(ctrl), 64'd0);
        cmp({tag, "_pump"}, 64'(pump), 64'd0);
        cmp({tag, "_sel"}, 64'(collect_sel), 64'd0);
        cmp({tag, "_busy"}, 64'(busy), 64'd0);
        cmp({tag, "_done"}, 64'(done), 64'd0);
        cmp({tag, "_aborted"}, 64'(aborted), 64'd0);
    endtask

    // monitor: closes a phase record whenever ctrl leaves a non-idle pattern
    logic [10:0] cur_ctrl = '0;
    logic [4:0]  cur_sel = '0;
    logic [35:0] trace = '0;
    logic [2:0]  settle_or = '0;
    int          dur = 0;
    always @(negedge clk) begin
        rec_t e, g;
        if (!rst_n) begin
            cur_ctrl = '0;
            dur = 0;
        end else begin
            if (ctrl !== cur_ctrl) begin
                if (cur_ctrl != '0) begin
                    g.ctrl  = cur_ctrl;
                    g.dur   = dur;
                    g.sel   = cur_sel;
                    g.trace = trace;
                    g.stat  = {settle_or, ctrl, pump, done, aborted, busy};
                    if (exp_q.size() == 0) begin
                        cmp("unexpected_phase", 64'(cur_ctrl), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("phase_ctrl", 64'(g.ctrl), 64'(e.ctrl));
                        cmp("phase_cycles", 64'(g.dur), 64'(e.dur));
                        cmp("phase_collect_sel", 64'(g.sel), 64'(e.sel));
                        cmp("phase_pump_trace", 64'(g.trace), 64'(e.trace));
                        cmp("phase_end_status", 64'(g.stat), 64'(e.stat));
                    end
                end
                cur_ctrl  = ctrl;
                cur_sel   = collect_sel;
                dur       = 0;
                trace     = '0;
                settle_or = '0;
            end
            if (ctrl != '0) begin
                if (dur < 4) settle_or = settle_or | pump;
                else if (dur < 16) trace[(dur-4)*3 +: 3] = pump;
                dur++;
            end
        end
    end

    initial begin
        #23;
        check_zero_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        // basic run, then zero-stroke runs walking the outlet through a full wrap
        full_run(1, 2, 1, 5'b00001);
        full_run(0, 0, 0, 5'b00010);
        full_run(0, 1, 0, 5'b00100);
        full_run(0, 0, 0, 5'b01000);
        full_run(0, 0, 0, 5'b10000);
        full_run(0, 0, 1, 5'b00001);
        // abort mid-WASH with start held alongside
        push(P_LYS, 1, 16, 5'b0, P_WSH, 1'b0, 1'b0, 1'b1);
        push(P_WSH, 2, 11, 5'b0, 11'h000, 1'b0, 1'b1, 1'b0);
        pulse_start(1, 2, 1);
        wait_ctrl(P_WSH);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        cmp("abort_start_ignored_busy", 64'(busy), 64'd0);
        full_run(0, 0, 0, 5'b00010);
        // reset during the first ELUTE stroke
        push(P_LYS, 0, 4, 5'b0, P_WSH, 1'b0, 1'b0, 1'b1);
        push(P_WSH, 0, 4, 5'b0, P_ELU, 1'b0, 1'b0, 1'b1);
        pulse_start(0, 0, 2);
        wait_ctrl(P_ELU);
        repeat (6) @(negedge clk);
        cmp("pre_reset_pump", 64'(pump), 64'(3'b100));
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        // abort while idle must do nothing
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cmp("idle_abort_aborted", 64'(aborted), 64'd0);
        cmp("idle_abort_busy", 64'(busy), 64'd0);
        full_run(0, 0, 0, 5'b00001);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) cmp("missing_phases", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
